// File: rtl/pad_seq.sv
// Padding sequencer: passes message words, then selects pad, zero and length
// words on pktmux so each padded message ends on a BLK-word boundary.
module pad_seq #(
  parameter int w   = 64,
  parameter int BLK = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  input  logic         out_ready,
  output logic         out_valid,
  output logic         pad_pkt,
  output logic         zero_pkt,
  output logic         mgln_pkt,
  output logic [w-1:0] msg_len,
  output logic         blk_end,
  output logic         done
);

  localparam int IW = (BLK > 1) ? $clog2(BLK) : 1;
  localparam logic [IW-1:0] LAST = IW'(BLK - 1);
  localparam logic [w-1:0]  WLEN = w'(w);

  typedef enum logic [2:0] {
    IDLE,
    MSG,
    PAD,
    ZERO,
    LEN
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [w-1:0]  len_q, len_d;
  logic          done_q, done_d;

  logic          acc;
  logic [IW-1:0] idx_inc;

  assign idx_inc = (idx_q == LAST) ? '0 : idx_q + 1'b1;
  assign acc     = out_valid && out_ready;
  assign blk_end = acc && (idx_q == LAST);
  assign msg_len = len_q;
  assign done    = done_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    done_d    = 1'b0;
    out_valid = 1'b1;
    in_ready  = 1'b0;
    pad_pkt   = 1'b0;
    zero_pkt  = 1'b0;
    mgln_pkt  = 1'b0;
    unique case (state_q)
      IDLE, MSG: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        if (acc) begin
          idx_d   = idx_inc;
          len_d   = (state_q == IDLE) ? WLEN : len_q + WLEN;
          state_d = in_last ? PAD : MSG;
        end
      end
      PAD, ZERO: begin
        pad_pkt  = (state_q == PAD);
        zero_pkt = (state_q == ZERO);
        if (acc) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == LAST) ? LEN : ZERO;
        end
      end
      LEN: begin
        mgln_pkt = 1'b1;
        if (acc) begin
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_pad_seq.sv
// Bench for pad_seq: word-stream model of padded messages, random
// backpressure, gaps, junk inputs during padding, and mid-sequence reset.
module tb_pad_seq;
  localparam int W   = 64;
  localparam int BLK = 16;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         in_valid, in_last, in_ready;
  logic         out_ready, out_valid;
  logic         pad_pkt, zero_pkt, mgln_pkt;
  logic [W-1:0] msg_len;
  logic         blk_end, done;

  pad_seq #(.w(W), .BLK(BLK)) dut (
    .clk(clk), .rst_b(rst_b),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid),
    .pad_pkt(pad_pkt), .zero_pkt(zero_pkt), .mgln_pkt(mgln_pkt),
    .msg_len(msg_len), .blk_end(blk_end), .done(done)
  );

  always #5 clk = ~clk;

  // word kinds: 0 message, 1 pad, 2 zero, 3 length
  typedef struct {
    int          typ;
    bit          last;
    logic [63:0] len;
  } ent_t;

  ent_t q[$];
  int   pos;
  bit   done_exp;
  int   errs   = 0;
  int   checks = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_msg(int n);
    ent_t        e;
    int          total;
    logic [63:0] len;
    total = ((n + 2 + BLK - 1) / BLK) * BLK;
    len   = 64'(n) * 64'(W);
    for (int i = 0; i < n; i++) begin
      e.typ = 0; e.last = (i == n - 1); e.len = '0;
      q.push_back(e);
    end
    e.last = 0; e.len = len;
    e.typ = 1; q.push_back(e);
    e.typ = 2;
    for (int i = 0; i < total - n - 2; i++) q.push_back(e);
    e.typ = 3; q.push_back(e);
  endtask

  task automatic run(bit stall, bit gaps, bit hold, int abort);
    ent_t c;
    bit   ov, acc;
    int   cyc, popped;
    cyc = 0;
    popped = 0;
    while (q.size() > 0) begin
      c = q[0];
      @(posedge clk); #1;
      out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (c.typ == 0) begin
        in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_last  = c.last;
      end else begin
        in_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
        in_last  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      ov  = (c.typ == 0) ? in_valid : 1'b1;
      acc = ov && out_ready;
      chk("out_valid", out_valid, ov);
      chk("in_ready", in_ready, (c.typ == 0) ? out_ready : 1'b0);
      chk("pad_pkt", pad_pkt, c.typ == 1);
      chk("zero_pkt", zero_pkt, c.typ == 2);
      chk("mgln_pkt", mgln_pkt, c.typ == 3);
      chk("blk_end", blk_end, acc && (pos == BLK - 1));
      chk("done", done, done_exp);
      if (c.typ != 0) chk("msg_len", msg_len, c.len);
      if (abort >= 0 && popped >= abort && c.typ == 2) begin
        #2 rst_b = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_pad", pad_pkt, 0);
        chk("rst_zero", zero_pkt, 0);
        chk("rst_mgln", mgln_pkt, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, out_ready);
        chk("rst_msg_len", msg_len, 0);
        chk("rst_done", done, 0);
        #1 rst_b = 1'b1;
        q.delete();
        pos = 0;
        done_exp = 0;
        return;
      end
      done_exp = acc && (c.typ == 3);
      if (acc) begin
        void'(q.pop_front());
        pos = (pos + 1) % BLK;
        popped++;
      end
      cyc++;
      if (cyc > 5000) begin
        chk("timeout", 1, 0);
        q.delete();
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_last   = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_done", done, done_exp);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_in_ready", in_ready, out_ready);
      chk("idle_sel", {pad_pkt, zero_pkt, mgln_pkt}, 0);
      chk("idle_blk_end", blk_end, 0);
      done_exp = 0;
    end
  endtask

  initial begin
    rst_b = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    pos = 0;
    done_exp = 0;
    #3;
    chk("reset_sel", {pad_pkt, zero_pkt, mgln_pkt}, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_msg_len", msg_len, 0);
    chk("reset_done", done, 0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("reset_in_ready1", in_ready, 1);
    chk("reset_out_valid1", out_valid, 1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;

    add_msg(1);  run(0, 0, 0, -1); idle(2);
    add_msg(14); run(0, 0, 0, -1); idle(1);
    add_msg(15); run(0, 0, 0, -1); idle(1);
    add_msg(1);  add_msg(3); run(1, 1, 0, -1); idle(1);
    add_msg(1);  run(0, 0, 0, 5);
    add_msg(2);  run(0, 0, 0, -1); idle(1);
    add_msg(5);  add_msg(3); run(0, 0, 1, -1); idle(1);
    repeat (30) begin
      add_msg($urandom_range(1, 40));
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), -1);
      idle($urandom_range(0, 2));
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
